// File: rtl/fc_cmd_scheduler_pkg.sv
// Shared definitions for the fast-control command scheduler:
// fc_word bit indices, L1A source indices, calibration FSM states.
package fc_cmd_scheduler_pkg;

  localparam int FC_BCR  = 0;
  localparam int FC_L1A  = 1;
  localparam int FC_LRST = 2;
  localparam int FC_BCLR = 3;
  localparam int FC_CAL  = 5;

  localparam int SRC_SW    = 0;
  localparam int SRC_EXT   = 1;
  localparam int SRC_TIMER = 2;
  localparam int SRC_RSVD  = 3;

  typedef enum logic [2:0] {
    CAL_IDLE,
    CAL_ALIGN,
    CAL_PULSE,
    CAL_WAIT,
    CAL_FIRE
  } cal_state_t;

  // Pulse cycles remaining after the first one; length 0 acts as 1.
  function automatic logic [3:0] pulse_last(
    input logic [3:0] len
  );
    return (len == 4'd0) ? 4'd0 : len - 4'd1;
  endfunction

endpackage

// File: rtl/fc_cmd_scheduler_if.sv
// Request/config/status bundle of the fast-control scheduler.
// master: request source + config owner; slave: the scheduler.
interface fc_cmd_scheduler_if #(
  parameter int ORB_W  = 12,
  parameter int VETO_W = 12,
  parameter int CNT_W  = 16
);
  logic [ORB_W-1:0]  bx_counter;
  logic [3:0]        req_l1a;
  logic              req_link_reset;
  logic              req_buffer_clear;
  logic              req_calib;
  logic              busy;
  logic              enable_veto_busy;
  logic [VETO_W-1:0] l1a_veto_len;
  logic [ORB_W-1:0]  cmd_bx;
  logic [ORB_W-1:0]  calib_bx;
  logic [3:0]        calib_pulse_len;
  logic [7:0]        calib_l1a_offset;
  logic              clear_counters;
  logic [7:0]        fc_word;
  logic              veto_active;
  logic              calib_active;
  logic [1:0]        cmd_pending;
  logic [CNT_W-1:0]  vetoed_count;
  logic [CNT_W-1:0]  dropped_count;

  modport master (
    output bx_counter, req_l1a,
    output req_link_reset,
    output req_buffer_clear,
    output req_calib, busy,
    output enable_veto_busy,
    output l1a_veto_len, cmd_bx,
    output calib_bx,
    output calib_pulse_len,
    output calib_l1a_offset,
    output clear_counters,
    input  fc_word, veto_active,
    input  calib_active,
    input  cmd_pending,
    input  vetoed_count,
    input  dropped_count
  );

  modport slave (
    input  bx_counter, req_l1a,
    input  req_link_reset,
    input  req_buffer_clear,
    input  req_calib, busy,
    input  enable_veto_busy,
    input  l1a_veto_len, cmd_bx,
    input  calib_bx,
    input  calib_pulse_len,
    input  calib_l1a_offset,
    input  clear_counters,
    output fc_word, veto_active,
    output calib_active,
    output cmd_pending,
    output vetoed_count,
    output dropped_count
  );
endinterface

// File: rtl/fc_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats inc).
// Ports: clk_bx, reset_n, clear, inc, count.
module fc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_bx,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fc_cmd_scheduler.sv
// Fast-control scheduler: BCR, merged/vetoed L1A, orbit-aligned
// link reset / buffer clear, calibration pulse + L1A sequencer.
// Ports: clk_bx, reset_n, bus (slave side of fc_cmd_scheduler_if).
module fc_cmd_scheduler
  import fc_cmd_scheduler_pkg::*;
#(
  parameter int ORB_W  = 12,
  parameter int VETO_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic clk_bx,
  input  logic reset_n,
  fc_cmd_scheduler_if.slave bus
);

  cal_state_t        state;
  logic [3:0]        pcnt;
  logic [7:0]        ocnt;
  logic [7:0]        ocnt_dec;
  logic [VETO_W-1:0] veto_cnt;
  logic [ORB_W-1:0]  bx;
  logic              lr_pend;
  logic              bc_pend;
  logic              bcr_q;
  logic              l1a_q;
  logic              lrst_q;
  logic              bclr_q;
  logic              cal_q;
  logic              cal_fire;
  logic              l1a_src;
  logic              veto;
  logic              l1a_go;
  logic              cmd_hit;
  logic              lr_go;
  logic              bc_go;
  logic              veto_inc;
  logic              drop_inc;

  assign bx       = bus.bx_counter;
  assign cmd_hit  = bx == bus.cmd_bx;
  assign lr_go    = cmd_hit & lr_pend;
  assign bc_go    = cmd_hit & bc_pend & ~lr_pend;
  assign ocnt_dec = (ocnt != 8'd0) ? ocnt - 8'd1 : 8'd0;

  // Asserted in the cycle before FIRE so the calibration L1A
  // lands in fc_word together with the FIRE state.
  assign cal_fire =
    (state == CAL_PULSE && pcnt == 4'd0 && ocnt <= 8'd1) ||
    (state == CAL_WAIT && ocnt == 8'd1);

  assign l1a_src  = (|bus.req_l1a) | cal_fire;
  assign veto     = (veto_cnt != '0) |
                    (bus.busy & bus.enable_veto_busy);
  assign l1a_go   = l1a_src & ~veto;
  assign veto_inc = l1a_src & veto;
  assign drop_inc = bus.req_calib & (state != CAL_IDLE);

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      bcr_q    <= 1'b0;
      l1a_q    <= 1'b0;
      lrst_q   <= 1'b0;
      bclr_q   <= 1'b0;
      veto_cnt <= '0;
      lr_pend  <= 1'b0;
      bc_pend  <= 1'b0;
    end else begin
      bcr_q  <= bx == '0;
      l1a_q  <= l1a_go;
      lrst_q <= lr_go;
      bclr_q <= bc_go;
      if (l1a_go | bc_go) begin
        veto_cnt <= bus.l1a_veto_len;
      end else if (veto_cnt != '0) begin
        veto_cnt <= veto_cnt - 1'b1;
      end
      if (lr_go) begin
        lr_pend <= 1'b0;
      end else if (bus.req_link_reset) begin
        lr_pend <= 1'b1;
      end
      if (bc_go) begin
        bc_pend <= 1'b0;
      end else if (bus.req_buffer_clear) begin
        bc_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      state <= CAL_IDLE;
      pcnt  <= 4'd0;
      ocnt  <= 8'd0;
      cal_q <= 1'b0;
    end else begin
      cal_q <= 1'b0;
      unique case (state)
        CAL_IDLE: begin
          if (bus.req_calib) begin
            state <= CAL_ALIGN;
          end
        end
        CAL_ALIGN: begin
          if (bx == bus.calib_bx) begin
            state <= CAL_PULSE;
            pcnt  <= pulse_last(bus.calib_pulse_len);
            ocnt  <= bus.calib_l1a_offset;
            cal_q <= 1'b1;
          end
        end
        CAL_PULSE: begin
          ocnt <= ocnt_dec;
          if (pcnt != 4'd0) begin
            pcnt  <= pcnt - 4'd1;
            cal_q <= 1'b1;
          end else if (cal_fire) begin
            state <= CAL_FIRE;
          end else begin
            state <= CAL_WAIT;
          end
        end
        CAL_WAIT: begin
          ocnt <= ocnt_dec;
          if (cal_fire) begin
            state <= CAL_FIRE;
          end
        end
        CAL_FIRE: begin
          state <= CAL_IDLE;
        end
        default: begin
          state <= CAL_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.fc_word          = '0;
    bus.fc_word[FC_BCR]  = bcr_q;
    bus.fc_word[FC_L1A]  = l1a_q;
    bus.fc_word[FC_LRST] = lrst_q;
    bus.fc_word[FC_BCLR] = bclr_q;
    bus.fc_word[FC_CAL]  = cal_q;
  end

  // busy is a live input; hold the flag low while in reset.
  assign bus.veto_active  = reset_n & veto;
  assign bus.calib_active = state != CAL_IDLE;
  assign bus.cmd_pending  = {bc_pend, lr_pend};

  fc_sat_counter #(.W(CNT_W)) u_vetoed (
    .clk_bx  (clk_bx),
    .reset_n (reset_n),
    .clear   (bus.clear_counters),
    .inc     (veto_inc),
    .count   (bus.vetoed_count)
  );

  fc_sat_counter #(.W(CNT_W)) u_dropped (
    .clk_bx  (clk_bx),
    .reset_n (reset_n),
    .clear   (bus.clear_counters),
    .inc     (drop_inc),
    .count   (bus.dropped_count)
  );

endmodule

// File: tb/tb_fc_cmd_scheduler.sv
// Bench for fc_cmd_scheduler: event-time reference model feeding a
// scoreboard, directed scenarios, then randomized traffic.
module tb_fc_cmd_scheduler;
  import fc_cmd_scheduler_pkg::*;

  localparam int ORBIT = 160;
  localparam int SAT   = 65535;

  logic clk_bx  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_bx = ~clk_bx;

  fc_cmd_scheduler_if #(
    .ORB_W(12), .VETO_W(12), .CNT_W(16)
  ) bus ();

  fc_cmd_scheduler #(
    .ORB_W(12), .VETO_W(12), .CNT_W(16)
  ) dut (
    .clk_bx  (clk_bx),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] fc;
    logic [1:0] pend;
    logic       cal;
    int         vet;
    int         drp;
  } exp_t;

  exp_t sb[$];
  int l1a_log[$];
  int cal_log[$];
  int lrst_log[$];
  int bclr_log[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int bx     = 0;

  // reference model state, in absolute cycle numbers
  int veto_end = 0;
  bit lr_p = 0;
  bit bc_p = 0;
  int ph   = 0;
  int cal_p = 0;
  int cal_l = 0;
  int fire  = 0;
  int vet  = 0;
  int drp  = 0;

  always @(posedge clk_bx) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_bx);
      if (reset_n) begin
        if (bus.fc_word[FC_L1A])  l1a_log.push_back(cyc);
        if (bus.fc_word[FC_CAL])  cal_log.push_back(cyc);
        if (bus.fc_word[FC_LRST]) lrst_log.push_back(cyc);
        if (bus.fc_word[FC_BCLR]) bclr_log.push_back(cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fc_word", bus.fc_word, e.fc);
        chk("cmd_pending", bus.cmd_pending, e.pend);
        chk("calib_active", bus.calib_active, e.cal);
        chk("vetoed_count", bus.vetoed_count, e.vet);
        chk("dropped_count", bus.dropped_count, e.drp);
      end
    end
  end

  task automatic clear_logs();
    l1a_log.delete();
    cal_log.delete();
    lrst_log.delete();
    bclr_log.delete();
  endtask

  task automatic idle_in();
    bus.req_l1a          = 4'd0;
    bus.req_link_reset   = 1'b0;
    bus.req_buffer_clear = 1'b0;
    bus.req_calib        = 1'b0;
    bus.clear_counters   = 1'b0;
  endtask

  task automatic model_reset();
    veto_end = 0;
    lr_p = 0;
    bc_p = 0;
    ph   = 0;
    vet  = 0;
    drp  = 0;
  endtask

  // One clock: apply current inputs, predict next fc_word/status.
  task automatic step();
    exp_t e;
    bit src, vt, go, lrg, bcg, drop;
    int c, len, off, vl;
    c = cyc;
    bus.bx_counter = 12'(bx);
    #1;
    vl = int'(bus.l1a_veto_len);
    e.fc = 8'd0;
    e.fc[FC_BCR] = (bx == 0);
    src = (bus.req_l1a != 4'd0) || (ph == 2 && c == fire - 1);
    vt  = (c < veto_end) || (bus.busy && bus.enable_veto_busy);
    chk("veto_active", bus.veto_active, vt);
    go = src && !vt;
    if (go) veto_end = c + 1 + vl;
    e.fc[FC_L1A] = go;
    lrg = 0;
    bcg = 0;
    if (bx == int'(bus.cmd_bx)) begin
      if (lr_p) lrg = 1;
      else if (bc_p) bcg = 1;
    end
    if (bcg) veto_end = c + 1 + vl;
    lr_p = lrg ? 1'b0 : (lr_p | bus.req_link_reset);
    bc_p = bcg ? 1'b0 : (bc_p | bus.req_buffer_clear);
    e.fc[FC_LRST] = lrg;
    e.fc[FC_BCLR] = bcg;
    drop = bus.req_calib && ph != 0;
    if (ph == 1 && bx == int'(bus.calib_bx)) begin
      len   = int'(bus.calib_pulse_len);
      off   = int'(bus.calib_l1a_offset);
      cal_p = c + 1;
      cal_l = (len == 0) ? 1 : len;
      fire  = cal_p + ((off > cal_l) ? off : cal_l);
      ph    = 2;
    end else if (ph == 2 && c == fire) begin
      ph = 0;
    end else if (ph == 0 && bus.req_calib) begin
      ph = 1;
    end
    e.fc[FC_CAL] = ph == 2 && c + 1 >= cal_p &&
                   c + 1 < cal_p + cal_l;
    e.cal = ph != 0;
    if (bus.clear_counters) begin
      vet = 0;
      drp = 0;
    end else begin
      if (src && vt && vet < SAT) vet++;
      if (drop && drp < SAT) drp++;
    end
    e.pend = {bc_p, lr_p};
    e.vet  = vet;
    e.drp  = drp;
    sb.push_back(e);
    @(posedge clk_bx);
    bx = (bx + 1) % ORBIT;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic l1a_pulse(input logic [3:0] v);
    bus.req_l1a = v;
    step();
    bus.req_l1a = 4'd0;
  endtask

  task automatic calib_pulse();
    bus.req_calib = 1'b1;
    step();
    bus.req_calib = 1'b0;
  endtask

  task automatic wait_l1a(input string nm, input int bound);
    int k;
    k = 0;
    while (l1a_log.size() == 0 && k < bound) begin
      step();
      k++;
    end
    if (l1a_log.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout got=none want=l1a", nm);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_bx);
    #1;
    idle_in();
    reset_n = 1'b0;
    #1;
    chk("rst_fc_word", bus.fc_word, 0);
    chk("rst_calib_active", bus.calib_active, 0);
    chk("rst_cmd_pending", bus.cmd_pending, 0);
    chk("rst_vetoed", bus.vetoed_count, 0);
    chk("rst_dropped", bus.dropped_count, 0);
    model_reset();
    repeat (2) @(posedge clk_bx);
    @(negedge clk_bx);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t, v0, d0, p;
    idle_in();
    bus.bx_counter       = '0;
    bus.busy             = 1'b0;
    bus.enable_veto_busy = 1'b0;
    bus.l1a_veto_len     = 12'd5;
    bus.cmd_bx           = 12'hfff;
    bus.calib_bx         = 12'hfff;
    bus.calib_pulse_len  = 4'd1;
    bus.calib_l1a_offset = 8'd0;
    #2;
    chk("rst_fc_word", bus.fc_word, 0);
    chk("rst_veto_active", bus.veto_active, 0);
    chk("rst_calib_active", bus.calib_active, 0);
    chk("rst_cmd_pending", bus.cmd_pending, 0);
    chk("rst_vetoed", bus.vetoed_count, 0);
    @(negedge clk_bx);
    reset_n = 1'b1;
    #1;
    run(4);

    // merged sources, veto window edges
    clear_logs();
    v0 = vet;
    l1a_pulse(4'b0011);
    run(2);
    chk("t1_one_l1a", l1a_log.size(), 1);
    chk("t1_vetoed_same", bus.vetoed_count, v0);
    if (l1a_log.size() > 0) begin
      t = l1a_log[0];
      while (cyc < t + 4) step();
      l1a_pulse(4'b0001);
      l1a_pulse(4'b0001);
      run(2);
      chk("t1_l1a_count", l1a_log.size(), 2);
      if (l1a_log.size() == 2)
        chk("t1_l1a_time", l1a_log[1], t + 6);
      chk("t1_vetoed", bus.vetoed_count, v0 + 1);
    end
    run(8);

    // busy veto
    clear_logs();
    v0 = vet;
    bus.busy = 1'b1;
    bus.enable_veto_busy = 1'b1;
    repeat (3) begin
      l1a_pulse(4'b0001);
      run(9);
    end
    chk("t2_busy_no_l1a", l1a_log.size(), 0);
    chk("t2_busy_vetoed", bus.vetoed_count, v0 + 3);
    bus.enable_veto_busy = 1'b0;
    repeat (3) begin
      l1a_pulse(4'b0001);
      run(9);
    end
    chk("t2_nobusy_l1a", l1a_log.size(), 3);
    chk("t2_nobusy_vetoed", bus.vetoed_count, v0 + 3);
    bus.busy = 1'b0;

    // link reset / buffer clear ordering
    clear_logs();
    bus.cmd_bx = 12'd100;
    bus.l1a_veto_len = 12'd8;
    while (bx != 50) step();
    bus.req_link_reset   = 1'b1;
    bus.req_buffer_clear = 1'b1;
    step();
    idle_in();
    chk("t3_pending", bus.cmd_pending, 2'b11);
    t = 0;
    while (bclr_log.size() == 0 && t < 2 * ORBIT + 10) begin
      step();
      t++;
    end
    v0 = vet;
    l1a_pulse(4'b0001);
    run(2);
    chk("t3_lrst_count", lrst_log.size(), 1);
    chk("t3_bclr_count", bclr_log.size(), 1);
    if (lrst_log.size() == 1 && bclr_log.size() == 1)
      chk("t3_bclr_gap", bclr_log[0] - lrst_log[0], ORBIT);
    chk("t3_clear_veto", bus.vetoed_count, v0 + 1);
    chk("t3_no_l1a", l1a_log.size(), 0);
    chk("t3_pending_done", bus.cmd_pending, 2'b00);
    run(10);

    // calibration, offset longer than pulse
    clear_logs();
    bus.cmd_bx           = 12'hfff;
    bus.l1a_veto_len     = 12'd0;
    bus.calib_bx         = 12'd10;
    bus.calib_pulse_len  = 4'd3;
    bus.calib_l1a_offset = 8'd20;
    d0 = drp;
    calib_pulse();
    run(30);
    calib_pulse();
    wait_l1a("t4_wait", 2 * ORBIT + 40);
    run(3);
    chk("t4_pulse_len", cal_log.size(), 3);
    if (cal_log.size() == 3 && l1a_log.size() > 0) begin
      chk("t4_pulse_cont", cal_log[2] - cal_log[0], 2);
      chk("t4_l1a_at", l1a_log[0] - cal_log[0], 20);
    end
    chk("t4_dropped", bus.dropped_count, d0 + 1);
    chk("t4_idle", bus.calib_active, 0);

    // calibration, offset shorter than pulse
    clear_logs();
    bus.calib_pulse_len  = 4'd4;
    bus.calib_l1a_offset = 8'd2;
    calib_pulse();
    wait_l1a("t5_wait", 2 * ORBIT + 40);
    run(3);
    chk("t5_pulse_len", cal_log.size(), 4);
    if (cal_log.size() > 0 && l1a_log.size() > 0)
      chk("t5_l1a_at", l1a_log[0] - cal_log[0], 4);

    // reset during the pulse
    bus.calib_pulse_len  = 4'd6;
    bus.calib_l1a_offset = 8'd10;
    clear_logs();
    calib_pulse();
    p = 0;
    while (cal_log.size() == 0 && p < 2 * ORBIT + 10) begin
      step();
      p++;
    end
    chk("t6_in_pulse", bus.fc_word[FC_CAL], 1);
    do_reset();
    clear_logs();
    run(200);
    chk("t6_no_l1a", l1a_log.size(), 0);
    chk("t6_no_pulse", cal_log.size(), 0);
    chk("t6_idle", bus.calib_active, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        bus.cmd_bx   = 12'($urandom_range(ORBIT + 20));
        bus.calib_bx = 12'($urandom_range(ORBIT - 1));
        bus.enable_veto_busy = 1'($urandom);
      end
      bus.req_l1a = ($urandom % 6 == 0) ? 4'($urandom) : 4'd0;
      bus.busy    = ($urandom % 5 == 0);
      bus.l1a_veto_len     = 12'($urandom % 8);
      bus.req_link_reset   = ($urandom % 60 == 0);
      bus.req_buffer_clear = ($urandom % 60 == 0);
      bus.req_calib        = ($urandom % 70 == 0);
      bus.calib_pulse_len  = 4'($urandom % 6);
      bus.calib_l1a_offset = 8'($urandom % 12);
      bus.clear_counters   = ($urandom % 500 == 0);
      step();
    end
    idle_in();
    run(4);
    @(negedge clk_bx);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_cmd_scheduler.md
# fc_cmd_scheduler

Fast-control command scheduler in the `clk_bx` domain. It arbitrates L1A requests from several sources, orbit-aligns link-reset and buffer-clear commands, and sequences calibration pulse + L1A pairs. It produces the 8-bit fast-control word that feeds the Hamming encoder and the L1 header FIFO. It also owns the L1A veto window and the vetoed/dropped statistics.

## Interface
Parameters:
- `ORB_W`, 12, width of the orbit/BX counter and the orbit-position configuration.
- `VETO_W`, 12, width of the L1A veto-length counter.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk_bx`  in  1  bunch-crossing clock (40 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `bx_counter`  in  ORB_W  current BX within the orbit; 0 marks orbit start.
- `req_l1a`  in  4  single-cycle L1A requests: [0] software, [1] external, [2] timer, [3] reserved.
- `req_link_reset`  in  1  single-cycle request.
- `req_buffer_clear`  in  1  single-cycle request.
- `req_calib`  in  1  single-cycle calibration-sequence request.
- `busy`  in  1  DAQ/occupancy busy, already synchronised to `clk_bx`.
- `enable_veto_busy`  in  1  when 1, `busy` vetoes L1As.
- `l1a_veto_len`  in  VETO_W  dead time after an issued L1A.
- `cmd_bx`  in  ORB_W  orbit position for link-reset/buffer-clear issue.
- `calib_bx`  in  ORB_W  orbit position for the calibration pulse start.
- `calib_pulse_len`  in  4  calibration pulse length in BX; 0 is treated as 1.
- `calib_l1a_offset`  in  8  number of BX from pulse start to calibration L1A.
- `clear_counters`  in  1  synchronous clear of the statistics counters.
- `fc_word`  out  8  [0] BCR, [1] L1A, [2] link reset, [3] buffer clear, [5] calib pulse; [4],[7:6] always 0.
- `veto_active`  out  1  current veto state.
- `calib_active`  out  1  calibration FSM is not in IDLE.
- `cmd_pending`  out  2  [0] link reset pending, [1] buffer clear pending.
- `vetoed_count`  out  CNT_W  L1A request-cycles that were vetoed.
- `dropped_count`  out  CNT_W  calibration requests ignored because a sequence was already active.

## Operation
- All `fc_word` bits are registered. An input in cycle N appears in `fc_word` at cycle N+1.
- **BCR:** `fc_word[0]` = 1 for the cycle after `bx_counter`==0. No other source affects it.
- **L1A merge:** the L1A source is the OR of `req_l1a` and the internal calibration L1A. A cycle with several sources produces one L1A and, if vetoed, one `vetoed_count` increment.
- **Veto:** `veto_active` = (`veto_cnt` != 0) | (`busy` & `enable_veto_busy`).
  - When an L1A is issued, `veto_cnt` loads `l1a_veto_len`. It decrements each cycle down to 0.
  - A vetoed L1A is dropped, never deferred.
- **Link reset / buffer clear:**
  - A request sets its pending flag. A request while already pending is absorbed.
  - A pending command issues in the cycle after `bx_counter`==`cmd_bx`. At most one command issues per orbit; link reset wins. If both are pending, buffer clear issues in the next orbit.
  - Issue clears that command's pending flag.
  - An issued buffer clear also loads `veto_cnt` with `l1a_veto_len`.
- **Calibration FSM:** IDLE → ALIGN → PULSE → WAIT → FIRE → IDLE.
  - IDLE: `req_calib` moves the FSM to ALIGN.
  - ALIGN: waits for `bx_counter`==`calib_bx`, then moves to PULSE and loads the pulse and offset counters.
  - PULSE: `fc_word[5]` is high for max(`calib_pulse_len`,1) cycles.
  - WAIT: holds until the offset counter expires.
  - FIRE: raises the internal L1A for one cycle; it is subject to veto like any other source.
  - If `calib_l1a_offset` ≤ pulse length, the L1A fires in the cycle after the pulse ends.
  - `req_calib` outside IDLE increments `dropped_count`.
- **Counters:** saturate at all-ones. `clear_counters` has priority over an increment in the same cycle.
- **Reset:** all outputs are 0 and the FSM is IDLE. Pending flags, `veto_cnt` and the counters are 0. Reset in mid-sequence aborts it with no further `fc_word[5]` or L1A.

## Timing
- Let P be the first `fc_word` cycle with bit5 high. The calibration L1A appears at P + max(`calib_l1a_offset`, pulse_len).
- If an L1A appears in `fc_word` at cycle T, no L1A appears at T+1 … T+`l1a_veto_len`. An L1A is allowed again at T+`l1a_veto_len`+1.
- `l1a_veto_len` = 0: back-to-back L1As are allowed unless `busy` vetoes them.
- `cmd_bx` ≥ orbit length: the command never issues and the pending flag stays set. This is legal and is observable on `cmd_pending`.
- Configuration inputs are sampled live. Changing them mid-sequence affects only counters not yet loaded.

## Structure
- The shared package holds:
  - `fc_word` bit-index constants `FC_BCR`, `FC_L1A`, `FC_LRST`, `FC_BCLR`, `FC_CAL`.
  - The calibration FSM state enum.
  - The `req_l1a` source-index constants.
- One sub-module, `fc_sat_counter`, implements the saturating counter with clear. It is instantiated twice.
- The FSM, veto and command-pending logic stay in the top level.

## Test plan
- `req_l1a`=4'b0011 in one cycle, `l1a_veto_len`=5 → exactly one `fc_word[1]` at N+1, `vetoed_count` unchanged. A request producing T+5 is dropped and counted; a request producing T+6 is issued.
- `busy`=1, `enable_veto_busy`=1, three software L1A pulses → no `fc_word[1]`, `vetoed_count`=3. Repeat with `enable_veto_busy`=0 → three L1As, subject to the veto window.
- `req_link_reset` and `req_buffer_clear` in the same cycle, `cmd_bx`=100 → `fc_word[2]` after BX 100 of the first orbit, `fc_word[3]` after BX 100 of the next orbit. A second L1A request inside `l1a_veto_len` after the clear is vetoed.
- `calib_bx`=10, `calib_pulse_len`=3, `calib_l1a_offset`=20 → bit5 high for 3 cycles from P, L1A at P+20. A second `req_calib` in mid-sequence gives `dropped_count`=1.
- `calib_l1a_offset`=2, `calib_pulse_len`=4 → L1A at P+4.
- Assert `reset_n` low during PULSE → outputs 0 immediately; after release, no L1A and `calib_active`=0.
